// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/period meter: state encoding,
// default widths and the counter saturation value.
package freq_meter_pkg;

  // Default counter width; the longest measurable period is 2^CNT_W-1 cycles.
  localparam int DEF_CNT_W = 28;

  // Default synchronizer depth on the asynchronous input.
  localparam int DEF_SYNC_STAGES = 2;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_WAIT = 2'd1,
    S_MEAS = 2'd2,
    S_TMO  = 2'd3
  } state_t;

  // All-ones value of a w-bit unsigned counter, used as the saturation point.
  function automatic logic [31:0] CNT_MAX(input int unsigned w);
    if (w >= 32)
      return 32'hFFFF_FFFF;
    else
      return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Brings the asynchronous sig_in into the clk domain and derives one-cycle
// rise/fall strobes from the synchronized level.
module sync_edge_det
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s_d;

  // Synchronizer chain followed by one delay flop for edge comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], sig_in};
      s_d    <= sync_p[SYNC_STAGES-1];
    end
  end

  assign s    = sync_p[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk
// cycles, strobing valid per completed period and flagging a stalled input.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout,
  output logic             measuring
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX(CNT_W));

  // The flush must outlast the full synchronizer plus edge-flop latency.
  localparam int              ARM_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;

  logic rise;
  logic fall;
  // The synchronized level itself is not needed; only its edges are.
  logic s_unused;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_in(sig_in),
    .s     (s_unused),
    .rise  (rise),
    .fall  (fall)
  );

  // Measurement FSM: arm flush, wait for first rise, count, saturate to timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_ARM;
      arm_cnt   <= '0;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      measuring <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        S_ARM: begin
          // Edges seen while the synchronizer is still filling are artefacts
          // of reset release, so they are ignored here.
          if (arm_cnt == ARM_LAST) begin
            state <= S_WAIT;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end

        S_WAIT: begin
          if (rise) begin
            state     <= S_MEAS;
            cnt       <= CNT_ONE;
            measuring <= 1'b1;
          end
        end

        S_MEAS: begin
          if (fall) begin
            hi_lat <= cnt;
          end
          // A rise on the saturating cycle still completes a valid period.
          if (rise) begin
            period    <= cnt;
            high_time <= hi_lat;
            valid     <= 1'b1;
            cnt       <= CNT_ONE;
          end else if (cnt == CNT_TOP) begin
            state     <= S_TMO;
            timeout   <= 1'b1;
            measuring <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_TMO: begin
          // The period that ended here is incomplete, so no valid is issued.
          if (rise) begin
            state     <= S_MEAS;
            cnt       <= CNT_ONE;
            timeout   <= 1'b0;
            measuring <= 1'b1;
          end
        end

        default: begin
          state <= S_ARM;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scenario bench for freq_meter: stimulus tasks push expected measurements
// computed from the edges they drive, a negedge monitor pops them on valid.
module tb_freq_meter;

  localparam int CNT_W     = 8;
  localparam int CNT_MAX_I = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             timeout;
  logic             measuring;

  typedef struct packed {
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi;
  } exp_t;

  exp_t exp_q[$];
  int   vtimes[$];

  int checks   = 0;
  int failures = 0;

  int               t         = 0;
  int               last_rise = 0;
  bit               armed     = 0;
  logic [CNT_W-1:0] exp_hi    = '0;
  int               cyc       = 0;
  int               tmo_seen  = 0;

  freq_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .measuring(measuring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Monitor: every valid strobe must match the oldest expected measurement.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (timeout === 1'b1) tmo_seen++;
    if (valid === 1'b1) begin
      vtimes.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d period=%0d high_time=%0d, none expected",
                 cyc, period, high_time);
      end else begin
        e = exp_q.pop_front();
        if (period !== e.per || high_time !== e.hi) begin
          failures++;
          $display("FAIL measurement: got period=%0d high_time=%0d, expected period=%0d high_time=%0d",
                   period, high_time, e.per, e.hi);
        end
      end
    end
  end

  // One clk cycle of stimulus; updates the expectation model from the edge driven.
  task automatic step(input logic v);
    exp_t e;
    if (v === 1'b1 && sig_in === 1'b0) begin
      if (armed && (t - last_rise) <= CNT_MAX_I) begin
        e.per = CNT_W'(t - last_rise);
        e.hi  = exp_hi;
        exp_q.push_back(e);
      end
      armed     = 1;
      last_rise = t;
    end else if (v === 1'b0 && sig_in === 1'b1) begin
      if (armed && (t - last_rise) <= CNT_MAX_I) exp_hi = CNT_W'(t - last_rise);
    end
    sig_in = v;
    t++;
    @(negedge clk);
  endtask

  // n full periods, then a closing high pulse so n+1 rises are produced.
  task automatic pulses(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) step(1'b1);
      repeat (per - hi) step(1'b0);
    end
    repeat (hi) step(1'b1);
    step(1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step(sig_in);
    rst_n  = 1'b1;
    armed  = 0;
    exp_hi = '0;
  endtask

  task automatic test_reset;
    sig_in = 1'b0;
    do_reset(3);
    checks++;
    if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || measuring !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: period=%0d high_time=%0d valid=%b timeout=%b measuring=%b, all required 0",
               period, high_time, valid, timeout, measuring);
    end
    repeat (6) step(1'b0);
    checks++;
    if (measuring !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: measuring=%b valid=%b, required 0 0", measuring, valid);
    end
  endtask

  task automatic test_basic;
    do_reset(2);
    repeat (5) step(1'b0);
    vtimes.delete();
    pulses(10, 4, 5);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain: %0d expected valids missing, required 0", exp_q.size());
    end
    checks++;
    if (vtimes.size() != 5) begin
      failures++;
      $display("FAIL basic_valid_count: got %0d valids, required 5", vtimes.size());
    end
    for (int i = 1; i < vtimes.size(); i++) begin
      checks++;
      if (vtimes[i] - vtimes[i-1] != 10) begin
        failures++;
        $display("FAIL basic_spacing: valid spacing %0d, required 10", vtimes[i] - vtimes[i-1]);
      end
    end
    checks++;
    if (measuring !== 1'b1) begin
      failures++;
      $display("FAIL basic_measuring: measuring=%b, required 1", measuring);
    end
  endtask

  task automatic test_half_duty;
    int tmo0;
    do_reset(2);
    repeat (5) step(1'b0);
    tmo0 = tmo_seen;
    pulses(16, 8, 4);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL half_duty_drain: %0d expected valids missing, required 0", exp_q.size());
    end
    checks++;
    if (tmo_seen != tmo0) begin
      failures++;
      $display("FAIL half_duty_timeout: timeout high for %0d cycles, required 0", tmo_seen - tmo0);
    end
  endtask

  task automatic test_high_at_reset;
    sig_in = 1'b1;
    do_reset(2);
    repeat (20) step(1'b1);
    repeat (10) step(1'b0);
    repeat (5) step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL high_at_reset_drain: %0d expected valids missing, required 0", exp_q.size());
    end
    checks++;
    if (measuring !== 1'b1) begin
      failures++;
      $display("FAIL high_at_reset_measuring: measuring=%b, required 1", measuring);
    end
  endtask

  task automatic test_timeout;
    do_reset(2);
    repeat (5) step(1'b0);
    pulses(10, 5, 2);
    while (t < last_rise + 257) step(1'b0);
    checks++;
    if (timeout !== 1'b0 || measuring !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: timeout=%b measuring=%b one cycle before saturation, required 0 1",
               timeout, measuring);
    end
    step(1'b0);
    checks++;
    if (timeout !== 1'b1 || measuring !== 1'b0) begin
      failures++;
      $display("FAIL timeout_set: timeout=%b measuring=%b at saturation, required 1 0", timeout, measuring);
    end
    repeat (20) step(1'b0);
    checks++;
    if (timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_hold: timeout=%b, required 1", timeout);
    end
    repeat (5) step(1'b1);
    repeat (5) step(1'b0);
    checks++;
    if (timeout !== 1'b0 || measuring !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear: timeout=%b measuring=%b after resume rise, required 0 1", timeout, measuring);
    end
    repeat (5) step(1'b1);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_drain: %0d expected valids missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_max_period;
    int tmo0;
    do_reset(2);
    repeat (5) step(1'b0);
    tmo0 = tmo_seen;
    pulses(CNT_MAX_I, 100, 2);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL max_period_drain: %0d expected valids missing, required 0", exp_q.size());
    end
    checks++;
    if (tmo_seen != tmo0) begin
      failures++;
      $display("FAIL max_period_timeout: timeout high for %0d cycles, required 0", tmo_seen - tmo0);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(2);
    repeat (5) step(1'b0);
    pulses(10, 4, 2);
    repeat (3) step(1'b0);
    do_reset(1);
    checks++;
    if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || measuring !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: period=%0d high_time=%0d valid=%b timeout=%b measuring=%b, all required 0",
               period, high_time, valid, timeout, measuring);
    end
    repeat (5) step(1'b0);
    pulses(12, 3, 2);
    repeat (8) step(1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_drain: %0d expected valids missing, required 0", exp_q.size());
    end
    checks++;
    if (period !== CNT_W'(12) || high_time !== CNT_W'(3)) begin
      failures++;
      $display("FAIL mid_reset_hold: period=%0d high_time=%0d, required 12 3", period, high_time);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    test_reset;
    test_basic;
    test_half_duty;
    test_high_at_reset;
    test_timeout;
    test_max_period;
    test_mid_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
